// File: rtl/cv32e40px_pkg.sv
// -----------------------------------------------------------------------------
// cv32e40px_pkg
// Shared package for the cv32e40px clock-enable controller slice.
// Provides the controller state encoding and the width of the idle
// hysteresis counter.
// No ports (package only).
// -----------------------------------------------------------------------------
package cv32e40px_pkg;

    // Controller states. The 3-bit encoding is fixed so that the state
    // register width does not depend on the tool's enum sizing.
    typedef enum logic [2:0] {
        OFF   = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        SLEEP = 3'd3,
        WAKE  = 3'd4
    } clk_en_state_e;

    // Width of the idle hysteresis counter. It is wide enough for IDLE_HYST
    // values up to 255.
    localparam int CLK_EN_HYST_W = 8;

endpackage

// File: rtl/cv32e40px_outstanding_cnt.sv
// -----------------------------------------------------------------------------
// cv32e40px_outstanding_cnt
// Saturating up/down counter of outstanding data-bus transactions, with a
// sticky protocol-error flag.
// Ports:
//   clk      - free-running clock
//   rst_n    - asynchronous active-low reset
//   inc      - a request was granted this cycle
//   dec      - a response (rvalid) arrived this cycle
//   err_set  - external request to set the sticky error flag
//   count    - current outstanding count
//   err      - sticky protocol error (cleared only by reset)
// -----------------------------------------------------------------------------
module cv32e40px_outstanding_cnt #(
    parameter  int MAX_OUTSTANDING = 2,
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    input  logic             err_set,
    output logic [CNT_W-1:0] count,
    output logic             err
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    // A grant and a response in the same cycle cancel out. An increment past
    // the maximum or a decrement below zero is a bus protocol violation:
    // the count holds its value and the error flag is latched until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            err   <= 1'b0;
        end else begin
            if (err_set) begin
                err <= 1'b1;
            end
            unique case ({inc, dec})
                2'b10: begin
                    if (count == MAX_CNT) begin
                        err <= 1'b1;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                2'b01: begin
                    if (count == '0) begin
                        err <= 1'b1;
                    end else begin
                        count <= count - CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/cv32e40px_clock_en_ctrl.sv
// -----------------------------------------------------------------------------
// cv32e40px_clock_en_ctrl
// Clock-enable controller placed directly in front of the core clock-gate
// cell. It runs on the ungated clock and decides when the core clock may be
// stopped (after WFI once the pipeline and bus traffic have drained) and when
// it must restart (interrupt or debug request).
// Ports:
//   clk_ungated_i   - free-running clock
//   rst_n           - asynchronous active-low reset
//   fetch_enable_i  - level; first high sample is latched sticky
//   wfi_i           - single-cycle pulse, core retired WFI
//   core_busy_i     - pipeline busy
//   data_req_i      - data-bus request
//   data_gnt_i      - data-bus grant
//   data_rvalid_i   - data-bus response valid
//   irq_pending_i   - enabled interrupt pending
//   debug_req_i     - debug request
//   clock_en_o      - enable to the clock gate (registered)
//   core_sleep_o    - core asleep with the clock stopped (registered)
//   wake_o          - single-cycle pulse on wake (registered)
//   outstanding_o   - outstanding data-bus transaction count
//   protocol_err_o  - sticky bus-protocol error flag
// -----------------------------------------------------------------------------
module cv32e40px_clock_en_ctrl
    import cv32e40px_pkg::*;
#(
    parameter  int IDLE_HYST       = 4,
    parameter  int MAX_OUTSTANDING = 2,
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk_ungated_i,
    input  logic             rst_n,
    input  logic             fetch_enable_i,
    input  logic             wfi_i,
    input  logic             core_busy_i,
    input  logic             data_req_i,
    input  logic             data_gnt_i,
    input  logic             data_rvalid_i,
    input  logic             irq_pending_i,
    input  logic             debug_req_i,
    output logic             clock_en_o,
    output logic             core_sleep_o,
    output logic             wake_o,
    output logic [CNT_W-1:0] outstanding_o,
    output logic             protocol_err_o
);

    localparam logic [CLK_EN_HYST_W-1:0] HYST_LAST = CLK_EN_HYST_W'(IDLE_HYST - 1);

    clk_en_state_e            state_q;
    clk_en_state_e            state_d;
    logic                     fetch_en_q;
    logic [CLK_EN_HYST_W-1:0] hyst_q;
    logic [CLK_EN_HYST_W-1:0] hyst_d;
    logic                     wake_cond;
    logic                     granted;
    logic                     idle;
    logic                     asleep;
    logic [CNT_W-1:0]         outstanding;

    assign wake_cond = irq_pending_i | debug_req_i;
    assign granted   = data_req_i & data_gnt_i;
    assign idle      = !core_busy_i && (outstanding == '0) && !granted;
    assign asleep    = (state_q == SLEEP);

    // While asleep the bus inputs are ignored for counting purposes; a
    // response arriving with the clock stopped is still flagged as an error.
    cv32e40px_outstanding_cnt #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_outstanding_cnt (
        .clk     (clk_ungated_i),
        .rst_n   (rst_n),
        .inc     (granted & !asleep),
        .dec     (data_rvalid_i & !asleep),
        .err_set (data_rvalid_i & asleep),
        .count   (outstanding),
        .err     (protocol_err_o)
    );

    assign outstanding_o = outstanding;

    // Next-state and hysteresis logic. In DRAIN a wake condition wins over
    // idle counting; SLEEP is entered on the cycle the counter would reach
    // IDLE_HYST, so the earliest WFI-to-SLEEP latency is IDLE_HYST+1 cycles.
    always_comb begin
        state_d = state_q;
        hyst_d  = hyst_q;
        unique case (state_q)
            OFF: begin
                if (fetch_enable_i || fetch_en_q) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (wfi_i && !wake_cond) begin
                    state_d = DRAIN;
                    hyst_d  = '0;
                end
            end
            DRAIN: begin
                if (wake_cond) begin
                    state_d = RUN;
                end else if (!idle) begin
                    hyst_d = '0;
                end else if (hyst_q == HYST_LAST) begin
                    state_d = SLEEP;
                end else begin
                    hyst_d = hyst_q + CLK_EN_HYST_W'(1);
                end
            end
            SLEEP: begin
                if (wake_cond) begin
                    state_d = WAKE;
                end
            end
            WAKE: begin
                state_d = RUN;
            end
            default: begin
                state_d = OFF;
            end
        endcase
    end

    // State, sticky fetch enable and the outputs. The outputs are decoded
    // from the next state and registered so that clock_en_o can only change
    // on a rising edge of the ungated clock and never glitches.
    always_ff @(posedge clk_ungated_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= OFF;
            fetch_en_q   <= 1'b0;
            hyst_q       <= '0;
            clock_en_o   <= 1'b0;
            core_sleep_o <= 1'b0;
            wake_o       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hyst_q       <= hyst_d;
            if (fetch_enable_i) begin
                fetch_en_q <= 1'b1;
            end
            clock_en_o   <= (state_d == RUN) || (state_d == DRAIN) || (state_d == WAKE);
            core_sleep_o <= (state_d == SLEEP);
            wake_o       <= (state_d == WAKE);
        end
    end

endmodule

// File: tb/tb_cv32e40px_clock_en_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cv32e40px_clock_en_ctrl
// Directed self-checking bench for the clock-enable controller with
// IDLE_HYST=4 and MAX_OUTSTANDING=2.
// -----------------------------------------------------------------------------
module tb_cv32e40px_clock_en_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       fetch_enable;
    logic       wfi;
    logic       core_busy;
    logic       data_req;
    logic       data_gnt;
    logic       data_rvalid;
    logic       irq_pending;
    logic       debug_req;
    logic       clock_en;
    logic       core_sleep;
    logic       wake;
    logic [1:0] outstanding;
    logic       protocol_err;

    int check_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;

    cv32e40px_clock_en_ctrl #(
        .IDLE_HYST       (4),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk_ungated_i  (clk),
        .rst_n          (rst_n),
        .fetch_enable_i (fetch_enable),
        .wfi_i          (wfi),
        .core_busy_i    (core_busy),
        .data_req_i     (data_req),
        .data_gnt_i     (data_gnt),
        .data_rvalid_i  (data_rvalid),
        .irq_pending_i  (irq_pending),
        .debug_req_i    (debug_req),
        .clock_en_o     (clock_en),
        .core_sleep_o   (core_sleep),
        .wake_o         (wake),
        .outstanding_o  (outstanding),
        .protocol_err_o (protocol_err)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it; outputs are sampled
    // and new inputs driven at that point.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        check_cnt++;
        assert (observed === expected) pass_cnt++;
        else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic ce, input logic sl, input logic wk,
                            input logic [1:0] cnt, input logic err);
        checkOutput({tag, ".clock_en"}, {7'd0, clock_en}, {7'd0, ce});
        checkOutput({tag, ".core_sleep"}, {7'd0, core_sleep}, {7'd0, sl});
        checkOutput({tag, ".wake"}, {7'd0, wake}, {7'd0, wk});
        checkOutput({tag, ".outstanding"}, {6'd0, outstanding}, {6'd0, cnt});
        checkOutput({tag, ".protocol_err"}, {7'd0, protocol_err}, {7'd0, err});
    endtask

    initial begin
        rst_n        = 1'b0;
        fetch_enable = 1'b0;
        wfi          = 1'b0;
        core_busy    = 1'b0;
        data_req     = 1'b0;
        data_gnt     = 1'b0;
        data_rvalid  = 1'b0;
        irq_pending  = 1'b0;
        debug_req    = 1'b0;

        // Reset values
        #12;
        checkAll("reset", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        applyStimulus();
        rst_n = 1'b1;

        // OFF until fetch enable; sticky once seen
        applyStimulus();
        checkAll("off_c1", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        applyStimulus();
        checkOutput("off_c2", {7'd0, clock_en}, 8'd0);
        fetch_enable = 1'b1;
        #2;
        checkOutput("off_c3_comb", {7'd0, clock_en}, 8'd0);
        applyStimulus();
        fetch_enable = 1'b0;
        checkAll("run_c4", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        applyStimulus();
        checkOutput("run_sticky", {7'd0, clock_en}, 8'd1);

        // WFI with everything idle: 4 enabled cycles then SLEEP
        wfi = 1'b1;
        applyStimulus();
        wfi = 1'b0;
        checkAll("drain_0", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        for (int i = 1; i < 4; i++) begin
            applyStimulus();
            checkOutput($sformatf("drain_%0d", i), {7'd0, clock_en}, 8'd1);
        end
        applyStimulus();
        checkAll("sleep", 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
        applyStimulus();
        checkOutput("sleep_hold", {7'd0, core_sleep}, 8'd1);

        // Interrupt wakes in one cycle with a one-cycle wake pulse
        irq_pending = 1'b1;
        applyStimulus();
        irq_pending = 1'b0;
        checkAll("wake", 1'b1, 1'b0, 1'b1, 2'd0, 1'b0);
        applyStimulus();
        checkAll("wake_run", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);

        // WFI with one outstanding load; drain waits for the response
        data_req = 1'b1;
        data_gnt = 1'b1;
        applyStimulus();
        data_req = 1'b0;
        data_gnt = 1'b0;
        checkOutput("load_cnt", {6'd0, outstanding}, 8'd1);
        wfi = 1'b1;
        applyStimulus();
        wfi = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            checkOutput($sformatf("drain_busy_%0d", i), {7'd0, clock_en}, 8'd1);
        end
        data_rvalid = 1'b1;
        applyStimulus();
        data_rvalid = 1'b0;
        checkAll("rvalid", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        for (int i = 1; i < 4; i++) begin
            applyStimulus();
            checkOutput($sformatf("post_rvalid_%0d", i), {7'd0, clock_en}, 8'd1);
        end
        applyStimulus();
        checkAll("sleep_after_load", 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);

        // Debug request wakes too
        debug_req = 1'b1;
        applyStimulus();
        debug_req = 1'b0;
        checkOutput("dbg_wake", {7'd0, wake}, 8'd1);
        applyStimulus();
        checkOutput("dbg_wake_done", {7'd0, wake}, 8'd0);

        // WFI coinciding with debug request is a NOP
        wfi       = 1'b1;
        debug_req = 1'b1;
        applyStimulus();
        wfi       = 1'b0;
        debug_req = 1'b0;
        for (int i = 0; i < 7; i++) begin
            checkOutput($sformatf("wfi_nop_%0d", i), {7'd0, clock_en}, 8'd1);
            applyStimulus();
        end

        // Debug request in DRAIN cycle 2 returns to RUN without wake pulse
        wfi = 1'b1;
        applyStimulus();
        wfi = 1'b0;
        applyStimulus();
        debug_req = 1'b1;
        applyStimulus();
        debug_req = 1'b0;
        checkAll("drain_abort", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus();
            checkOutput($sformatf("abort_run_%0d", i), {7'd0, clock_en}, 8'd1);
        end

        // Counter: simultaneous grant and rvalid cancel, then overflow
        data_req = 1'b1;
        data_gnt = 1'b1;
        applyStimulus();
        checkOutput("cnt_1", {6'd0, outstanding}, 8'd1);
        data_rvalid = 1'b1;
        applyStimulus();
        data_rvalid = 1'b0;
        checkOutput("cnt_both", {6'd0, outstanding}, 8'd1);
        applyStimulus();
        checkAll("cnt_2", 1'b1, 1'b0, 1'b0, 2'd2, 1'b0);
        applyStimulus();
        data_req = 1'b0;
        data_gnt = 1'b0;
        checkAll("cnt_overflow", 1'b1, 1'b0, 1'b0, 2'd2, 1'b1);
        data_rvalid = 1'b1;
        applyStimulus();
        applyStimulus();
        data_rvalid = 1'b0;
        checkAll("cnt_drained", 1'b1, 1'b0, 1'b0, 2'd0, 1'b1);

        // Reset clears the error and requires fetch enable again
        rst_n = 1'b0;
        #1;
        checkAll("reset2", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        applyStimulus();
        rst_n = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("reset2_off", {7'd0, clock_en}, 8'd0);

        // rvalid at count 0 underflows
        data_rvalid = 1'b1;
        applyStimulus();
        data_rvalid = 1'b0;
        checkAll("underflow", 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);

        // Reset again, enter SLEEP, then reset mid-SLEEP
        rst_n = 1'b0;
        applyStimulus();
        rst_n = 1'b1;
        fetch_enable = 1'b1;
        applyStimulus();
        checkOutput("refetch", {7'd0, clock_en}, 8'd1);
        wfi = 1'b1;
        applyStimulus();
        wfi = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus();
        end
        checkAll("sleep2", 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
        data_req  = 1'b1;
        data_gnt  = 1'b1;
        wfi       = 1'b1;
        core_busy = 1'b1;
        applyStimulus();
        data_req  = 1'b0;
        data_gnt  = 1'b0;
        wfi       = 1'b0;
        core_busy = 1'b0;
        checkAll("sleep_ignore", 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
        data_rvalid = 1'b1;
        applyStimulus();
        data_rvalid = 1'b0;
        checkAll("sleep_rvalid", 1'b0, 1'b1, 1'b0, 2'd0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkAll("reset_sleep", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        applyStimulus();
        checkOutput("reset_sleep_hold", {7'd0, clock_en}, 8'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/cv32e40px_clock_en_ctrl.md
Name: cv32e40px_clock_en_ctrl

Overview:
- Clock-enable controller directly upstream of the core clock-gate cell; its clock_en_o drives the gate's en_i.
- Runs on the ungated clock and decides when the core clock may stop: after fetch enable, after WFI once the pipeline and memory traffic have drained, and when an interrupt or debug request arrives.
- Tracks outstanding data-bus transactions so the clock never stops while a response is in flight.

Parameters:
- IDLE_HYST, default 4: consecutive idle cycles required in DRAIN before entering SLEEP; legal range 1..255.
- MAX_OUTSTANDING, default 2: maximum outstanding data-bus requests; sets the counter width to $clog2(MAX_OUTSTANDING+1).

Ports:
- clk_ungated_i, input, 1: free-running clock.
- rst_n, input, 1: reset.
- fetch_enable_i, input, 1: level; the first high sample is latched sticky.
- wfi_i, input, 1: single-cycle pulse, core retired WFI.
- core_busy_i, input, 1: pipeline busy.
- data_req_i, input, 1: data-bus request.
- data_gnt_i, input, 1: data-bus grant.
- data_rvalid_i, input, 1: data-bus response valid.
- irq_pending_i, input, 1: enabled interrupt pending.
- debug_req_i, input, 1: debug request.
- clock_en_o, output, 1: enable to the clock gate.
- core_sleep_o, output, 1: core is asleep with the clock stopped.
- wake_o, output, 1: single-cycle pulse on wake.
- outstanding_o, output, CNT_W: current outstanding transaction count.
- protocol_err_o, output, 1: sticky bus-protocol error flag.

Interface (already decided):
- One clock, clk_ungated_i.
- Reset rst_n is asynchronous and active-low.

Behaviour:
- Definitions:
  - wake_cond = irq_pending_i | debug_req_i.
  - idle = !core_busy_i & (outstanding == 0) & !(data_req_i & data_gnt_i).
- All outputs are registered or Moore decodes of registered state; no combinational input-to-output path.
- States: OFF, RUN, DRAIN, SLEEP, WAKE.
- Reset values: state=OFF, fetch_en_q=0, hyst_cnt=0, outstanding=0, protocol_err_o=0, clock_en_o=0, core_sleep_o=0, wake_o=0.
- OFF:
  - clock_en_o=0, core_sleep_o=0.
  - fetch_enable_i sampled high sets fetch_en_q; next cycle the state is RUN.
  - Deasserting fetch_enable_i later has no effect.
- RUN:
  - clock_en_o=1.
  - wfi_i with wake_cond in the same cycle: stay in RUN (WFI is a NOP).
  - wfi_i without wake_cond: go to DRAIN, hyst_cnt cleared.
- DRAIN:
  - clock_en_o=1.
  - wake_cond has priority: go to RUN, wake_o not pulsed.
  - Otherwise, idle increments hyst_cnt; !idle clears it.
  - When hyst_cnt==IDLE_HYST-1 and idle, go to SLEEP.
  - Minimum WFI-to-SLEEP latency is IDLE_HYST+1 cycles.
- SLEEP:
  - clock_en_o=0, core_sleep_o=1.
  - wake_cond: go to WAKE.
  - wfi_i, core_busy_i and data_* inputs are ignored, except that a data_rvalid_i here sets protocol_err_o.
- WAKE:
  - clock_en_o=1, core_sleep_o=0, wake_o=1 for exactly this one cycle.
  - Unconditionally go to RUN. Wake latency from wake_cond to clock_en_o=1 is 1 cycle.
- Outstanding counter:
  - +1 on data_req_i & data_gnt_i; -1 on data_rvalid_i; both in the same cycle leaves it unchanged.
  - Grant at MAX_OUTSTANDING without a concurrent rvalid: counter holds and protocol_err_o is set.
  - rvalid at 0 without a concurrent grant: counter holds at 0 and protocol_err_o is set.
  - protocol_err_o clears only on reset.
- Reset asserted in any state returns to OFF asynchronously with clock_en_o=0 immediately. After reset release, fetch enable must be seen again.
- clock_en_o only changes on clk_ungated_i rising edges. The downstream gate latches it in the low phase, so the gated clock is glitch-free.

Decomposition:
- Shared package cv32e40px_pkg gains:
  - clk_en_state_e enum: OFF, RUN, DRAIN, SLEEP, WAKE, 3-bit encoding.
  - CLK_EN_HYST_W = 8 constant.
- One natural sub-module, cv32e40px_outstanding_cnt: the saturating up/down counter with error flag, parameterised by MAX_OUTSTANDING.
- The FSM and hysteresis counter stay in the top module.

Test Plan:
- Reset, then fetch_enable_i=1 at cycle 3 -> clock_en_o=0 through cycle 3, =1 from cycle 4; state RUN.
- RUN, wfi_i pulse, all idle, IDLE_HYST=4 -> clock_en_o=1 for 4 cycles, then clock_en_o=0 and core_sleep_o=1 on the 5th cycle after the pulse.
- SLEEP, irq_pending_i=1 -> next cycle clock_en_o=1 and wake_o=1 for one cycle; the following cycle is RUN with wake_o=0.
- wfi_i with one outstanding load (outstanding_o=1); rvalid 6 cycles later -> remains in DRAIN with clock_en_o=1, reaches SLEEP 4 cycles after rvalid; protocol_err_o=0.
- wfi_i with debug_req_i high in the same cycle -> stays in RUN, clock_en_o never drops. Separately, debug_req_i at DRAIN cycle 2 -> back to RUN, wake_o=0.
- Error cases:
  - Three grants with MAX_OUTSTANDING=2 and no rvalid -> outstanding_o=2, protocol_err_o=1.
  - rvalid at count 0 -> outstanding_o=0, protocol_err_o=1.
  - rst_n low mid-SLEEP -> OFF with clock_en_o=0 and protocol_err_o=0.
